// File: rtl/funct_gen_pipe.sv
// Registered ALU funct generator between ID decode and the ID/EX register, with illegal-op
// flag and HI/LO busy stall. Optional SLTI/SLTIU/XORI decodes under FUNCT_EXT_EN.
module funct_gen_pipe #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [FUNCT_WIDTH-1:0] funct_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FUNCT_WIDTH-1:0] funct,
  output logic                   illegal,
  output logic                   md_busy,
  output logic [1:0]             o_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [OP_WIDTH-1:0] OP_SPECIAL = OP_WIDTH'(6'h00);
  localparam logic [OP_WIDTH-1:0] OP_JAL     = OP_WIDTH'(6'h03);
  localparam logic [OP_WIDTH-1:0] OP_ADDI    = OP_WIDTH'(6'h08);
  localparam logic [OP_WIDTH-1:0] OP_ADDIU   = OP_WIDTH'(6'h09);
  localparam logic [OP_WIDTH-1:0] OP_SLTI    = OP_WIDTH'(6'h0A);
  localparam logic [OP_WIDTH-1:0] OP_SLTIU   = OP_WIDTH'(6'h0B);
  localparam logic [OP_WIDTH-1:0] OP_ANDI    = OP_WIDTH'(6'h0C);
  localparam logic [OP_WIDTH-1:0] OP_ORI     = OP_WIDTH'(6'h0D);
  localparam logic [OP_WIDTH-1:0] OP_XORI    = OP_WIDTH'(6'h0E);
  localparam logic [OP_WIDTH-1:0] OP_LUI     = OP_WIDTH'(6'h0F);
  localparam logic [OP_WIDTH-1:0] OP_LB      = OP_WIDTH'(6'h20);
  localparam logic [OP_WIDTH-1:0] OP_LW      = OP_WIDTH'(6'h23);
  localparam logic [OP_WIDTH-1:0] OP_LBU     = OP_WIDTH'(6'h24);
  localparam logic [OP_WIDTH-1:0] OP_SB      = OP_WIDTH'(6'h28);
  localparam logic [OP_WIDTH-1:0] OP_SW      = OP_WIDTH'(6'h2B);

  localparam logic [FUNCT_WIDTH-1:0] F_NOP   = FUNCT_WIDTH'(6'h00);
  localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'h18);
  localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'h19);
  localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(6'h1A);
  localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(6'h1B);
  localparam logic [FUNCT_WIDTH-1:0] F_ADD   = FUNCT_WIDTH'(6'h20);
  localparam logic [FUNCT_WIDTH-1:0] F_ADDU  = FUNCT_WIDTH'(6'h21);
  localparam logic [FUNCT_WIDTH-1:0] F_AND   = FUNCT_WIDTH'(6'h24);
  localparam logic [FUNCT_WIDTH-1:0] F_OR    = FUNCT_WIDTH'(6'h25);
  localparam logic [FUNCT_WIDTH-1:0] F_XOR   = FUNCT_WIDTH'(6'h26);
  localparam logic [FUNCT_WIDTH-1:0] F_SLT   = FUNCT_WIDTH'(6'h2A);
  localparam logic [FUNCT_WIDTH-1:0] F_SLTU  = FUNCT_WIDTH'(6'h2B);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, MD_WAIT = 2'd2} state_t;

  state_t                 r_state;
  logic                   r_out_valid;
  logic [FUNCT_WIDTH-1:0] r_funct;
  logic                   r_illegal;
  logic                   r_md_busy;
  logic                   r_is_mult;
  logic                   r_is_div;
  logic [CW-1:0]          r_cnt;

  logic [FUNCT_WIDTH-1:0] w_dec_funct;
  logic                   w_dec_illegal;
  logic                   w_dec_mult;
  logic                   w_dec_div;
  logic                   w_accept;

  always_comb begin
    w_dec_funct   = F_NOP;
    w_dec_illegal = 1'b0;
    case (op)
      OP_SPECIAL:                                    w_dec_funct = funct_in;
      OP_LUI, OP_JAL, OP_ORI:                        w_dec_funct = F_OR;
      OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW, OP_ADDIU:  w_dec_funct = F_ADDU;
      OP_ADDI:                                       w_dec_funct = F_ADD;
      OP_ANDI:                                       w_dec_funct = F_AND;
`ifdef FUNCT_EXT_EN
      OP_SLTI:                                       w_dec_funct = F_SLT;
      OP_SLTIU:                                      w_dec_funct = F_SLTU;
      OP_XORI:                                       w_dec_funct = F_XOR;
`endif
      default:                                       w_dec_illegal = 1'b1;
    endcase
  end

`ifndef FUNCT_EXT_EN
  // Without the extension these opcodes fall through to the illegal default above.
  logic w_ext_unused;
  assign w_ext_unused = ^{OP_SLTI, OP_SLTIU, OP_XORI, F_SLT, F_SLTU, F_XOR};
`endif

  assign w_dec_mult = (op == OP_SPECIAL) && ((funct_in == F_MULT) || (funct_in == F_MULTU));
  assign w_dec_div  = (op == OP_SPECIAL) && ((funct_in == F_DIV)  || (funct_in == F_DIVU));

  // A held MULT/DIV that transfers moves straight into MD_WAIT, so nothing may be
  // accepted alongside it or that instruction would be lost.
  assign in_ready = !flush && (r_state != MD_WAIT) &&
                    (!r_out_valid || (out_ready && !(r_is_mult || r_is_div)));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_funct     <= F_NOP;
      r_illegal   <= 1'b0;
      r_md_busy   <= 1'b0;
      r_is_mult   <= 1'b0;
      r_is_div    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_funct     <= w_dec_funct;
            r_illegal   <= w_dec_illegal;
            r_is_mult   <= w_dec_mult;
            r_is_div    <= w_dec_div;
            r_out_valid <= 1'b1;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (flush) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_state     <= EMPTY;
          end else if (out_ready) begin
            if (r_is_mult) begin
              r_cnt       <= CW'(MULT_CYCLES - 1);
              r_out_valid <= 1'b0;
              r_md_busy   <= 1'b1;
              r_state     <= MD_WAIT;
            end else if (r_is_div) begin
              r_cnt       <= CW'(DIV_CYCLES - 1);
              r_out_valid <= 1'b0;
              r_md_busy   <= 1'b1;
              r_state     <= MD_WAIT;
            end else if (w_accept) begin
              r_funct   <= w_dec_funct;
              r_illegal <= w_dec_illegal;
              r_is_mult <= w_dec_mult;
              r_is_div  <= w_dec_div;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= EMPTY;
            end
          end
        end
        MD_WAIT: begin
          // flush is deliberately not looked at: the HI/LO operation is already committed.
          if (r_cnt == '0) begin
            r_md_busy <= 1'b0;
            r_state   <= EMPTY;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign funct     = r_funct;
  assign illegal   = r_illegal;
  assign md_busy   = r_md_busy;
  assign o_state   = r_state;

endmodule

// File: tb/tb_funct_gen_pipe.sv
// Bench for funct_gen_pipe: directed vectors with literal expectations, plus a
// transaction-level reference checked against the DUT every cycle.
module tb_funct_gen_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] op = 6'h00;
  logic [5:0] funct_in = 6'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] funct;
  logic       illegal;
  logic       md_busy;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  funct_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct_in(funct_in), .out_valid(out_valid), .out_ready(out_ready),
    .funct(funct), .illegal(illegal), .md_busy(md_busy), .o_state(o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: returns {illegal, funct}.
  function automatic logic [6:0] ref_decode(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:                                return {1'b0, f};
      6'h0F, 6'h03, 6'h0D:                  return {1'b0, 6'h25};
      6'h20, 6'h24, 6'h23, 6'h28, 6'h2B, 6'h09: return {1'b0, 6'h21};
      6'h08:                                return {1'b0, 6'h20};
      6'h0C:                                return {1'b0, 6'h24};
`ifdef FUNCT_EXT_EN
      6'h0A:                                return {1'b0, 6'h2A};
      6'h0B:                                return {1'b0, 6'h2B};
      6'h0E:                                return {1'b0, 6'h26};
`endif
      default:                              return {1'b1, 6'h00};
    endcase
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic       m_valid = 1'b0;
  logic [5:0] m_funct = 6'h00;
  logic       m_illegal = 1'b0;
  int         m_md_len = 0;   // HI/LO cycles the held entry will cost once it leaves
  int         m_busy = 0;     // HI/LO cycles still outstanding
  logic [5:0] exp_q[$];

  always @(negedge rst_n) begin
    m_valid = 1'b0; m_funct = 6'h00; m_illegal = 1'b0; m_md_len = 0; m_busy = 0;
    exp_q.delete();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic       exp_ready;
      logic [6:0] dec;
      exp_ready = !flush && (m_busy == 0) && (!m_valid || (out_ready && m_md_len == 0));
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, m_valid);
      check("md_busy", md_busy, m_busy > 0);
      if (m_valid) begin
        check("funct", funct, m_funct);
        check("illegal", illegal, m_illegal);
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) check("xfer_unexpected", 1, 0);
        else check("xfer_funct", funct, exp_q.pop_front());
      end
      // advance the model by one clock using the inputs now on the pins
      dec = ref_decode(op, funct_in);
      if (m_busy > 0) begin
        m_busy--;
      end else if (flush) begin
        if (m_valid) void'(exp_q.pop_front());
        m_valid = 1'b0;
      end else begin
        if (m_valid && out_ready) begin
          m_valid = 1'b0;
          m_busy  = m_md_len;
        end
        if (in_valid && exp_ready) begin
          m_valid   = 1'b1;
          m_funct   = dec[5:0];
          m_illegal = dec[6];
          m_md_len  = (op == 6'h00 && (funct_in == 6'h18 || funct_in == 6'h19)) ? 4 :
                      (op == 6'h00 && (funct_in == 6'h1A || funct_in == 6'h1B)) ? 32 : 0;
          exp_q.push_back(dec[5:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name, input int exp_n, input int flush_at);
    int n = 0;
    while (md_busy === 1'b1 && n < 100) begin
      flush = (n == flush_at);
      n++;
      step();
    end
    flush = 1'b0;
    check(name, n, exp_n);
  endtask

  localparam logic [5:0] RND_OPS[8]   = '{6'h00, 6'h0F, 6'h23, 6'h08, 6'h0C, 6'h0A, 6'h3F, 6'h2B};
  localparam logic [5:0] RND_FUNCT[4] = '{6'h18, 6'h1A, 6'h21, 6'h22};

  initial begin
    // reset state
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_funct", funct, 6'h00);
    check("rst_illegal", illegal, 0);
    check("rst_md_busy", md_busy, 0);
    rst_n = 1'b1;
    step();

    // back-to-back
    out_ready = 1'b1; in_valid = 1'b1;
    op = 6'h0F; step(); check("b2b_lui", funct, 6'h25);
    op = 6'h23; step(); check("b2b_lw", funct, 6'h21);
    op = 6'h08; step(); check("b2b_addi", funct, 6'h20);
    op = 6'h0C; step(); check("b2b_andi", funct, 6'h24);
    check("b2b_valid", out_valid, 1);
    in_valid = 1'b0; step();

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; op = 6'h0D; step();
    check("bp_ori", funct, 6'h25);
    op = 6'h09;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_funct", funct, 6'h25);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1; step();
    check("bp_second", funct, 6'h21);
    in_valid = 1'b0; step();

    // asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; op = 6'h09; step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_funct", funct, 6'h00);
    check("arst_md_busy", md_busy, 0);
    #1 rst_n = 1'b1;
    step();
    check("arst_first_valid", out_valid, 1);
    check("arst_first_funct", funct, 6'h21);
    out_ready = 1'b1; in_valid = 1'b0; step();

    // DIV stall, with a flush during the wait
    op = 6'h00; funct_in = 6'h1A; in_valid = 1'b1; step();
    check("div_funct", funct, 6'h1A);
    op = 6'h09;
    #1 check("div_xfer_ready", in_ready, 0);
    step();
    count_busy("div_busy_cycles", 32, 5);
    #1 check("div_ready_after", in_ready, 1);
    step();
    check("div_next_funct", funct, 6'h21);
    in_valid = 1'b0; step();

    // flush priority
    out_ready = 1'b0; in_valid = 1'b1; op = 6'h0D; step();
    flush = 1'b1; op = 6'h09;
    #1 check("flush_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_cleared", out_valid, 0);
    step();
    check("flush_not_accepted", out_valid, 0);

    // flushed MULT never starts
    op = 6'h00; funct_in = 6'h18; in_valid = 1'b1; step();
    flush = 1'b1; in_valid = 1'b0; step();
    flush = 1'b0; out_ready = 1'b1; step();
    check("fmult_busy0", md_busy, 0);
    step();
    check("fmult_busy1", md_busy, 0);

    // MULTU goes through
    funct_in = 6'h19; in_valid = 1'b1; step();
    check("multu_funct", funct, 6'h19);
    in_valid = 1'b0; step();
    count_busy("mult_busy_cycles", 4, -1);

    // illegal / extension
    in_valid = 1'b1; op = 6'h0A; step();
`ifdef FUNCT_EXT_EN
    check("slti_funct", funct, 6'h2A);
    check("slti_illegal", illegal, 0);
`else
    check("slti_funct", funct, 6'h00);
    check("slti_illegal", illegal, 1);
`endif
    op = 6'h3F; step();
    check("op3f_funct", funct, 6'h00);
    check("op3f_illegal", illegal, 1);
    in_valid = 1'b0; step();

    // mixed traffic, checked by the model
    for (int i = 0; i < 120; i++) begin
      op        = RND_OPS[$urandom_range(0, 7)];
      funct_in  = RND_FUNCT[$urandom_range(0, 3)];
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
